// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory request/response bus between the MEM-stage access unit and the
// data memory.
//   mem_req_o   : request valid, held until the acknowledging cycle
//   mem_we_o    : 1 = store, 0 = load
//   mem_addr_o  : word-aligned byte address
//   mem_wdata_o : store data
//   mem_ack_i   : one-cycle completion pulse from memory
//   mem_rdata_i : load data, valid together with mem_ack_i
// master = access unit, slave = memory.
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store sequencer. An aligned memory op in EX/MEM stalls the
// pipeline, issues one registered request on the memory bus and waits for
// the ack (or a timeout), then presents the result to MEM/WB for one cycle.
// Misaligned ops are flagged and turned into a bubble without a request.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-low reset
//   valid_i, MemRead_i, MemWrite_i, WB_i, addr_i, wdata_i, RegDst_i
//                         : EX/MEM pipeline register contents
//   mem                   : data-memory bus (master side)
//   stall_o               : freeze PC, IF/ID, ID/EX, EX/MEM
//   WB_o, data_o, addr_o, RegDst_o : toward MEM/WB
//   misalign_o            : misaligned access (combinational)
//   timeout_o             : one-cycle pulse in the DONE cycle after a timeout
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  WB_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  RegDst_i,
    mem_access_unit_if.master mem,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [31:0] data_o,
    output logic [31:0] addr_o,
    output logic [4:0]  RegDst_o,
    output logic        misalign_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt, view;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:0] hold, hold_nxt;
    logic        req_nxt, we_nxt, tmo_nxt;
    logic [31:0] maddr_nxt, mwdata_nxt;
    logic        memop, aligned;

    assign memop   = valid_i & (MemRead_i | MemWrite_i);
    assign aligned = (addr_i[1:0] == 2'b00);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state           <= IDLE;
            cnt             <= '0;
            hold            <= '0;
            timeout_o       <= 1'b0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            hold            <= hold_nxt;
            timeout_o       <= tmo_nxt;
            mem.mem_req_o   <= req_nxt;
            mem.mem_we_o    <= we_nxt;
            mem.mem_addr_o  <= maddr_nxt;
            mem.mem_wdata_o <= mwdata_nxt;
        end
    end

    always_comb begin
        // While reset is asserted the pipeline-facing outputs behave as IDLE,
        // whatever state the register still holds.
        view       = rst_i ? state : IDLE;
        state_nxt  = state;
        cnt_nxt    = cnt;
        hold_nxt   = hold;
        tmo_nxt    = 1'b0;
        req_nxt    = mem.mem_req_o;
        we_nxt     = mem.mem_we_o;
        maddr_nxt  = mem.mem_addr_o;
        mwdata_nxt = mem.mem_wdata_o;
        stall_o    = 1'b0;
        WB_o       = 2'b00;
        data_o     = '0;
        addr_o     = addr_i;
        RegDst_o   = RegDst_i;
        misalign_o = 1'b0;

        case (view)
            IDLE: begin
                if (!memop) begin
                    WB_o = valid_i ? WB_i : 2'b00;
                end else if (!aligned) begin
                    misalign_o = 1'b1;
                end else begin
                    // Bubble this cycle; request goes out registered next edge.
                    // Read+write together is a store.
                    stall_o    = 1'b1;
                    state_nxt  = WAIT;
                    req_nxt    = 1'b1;
                    we_nxt     = MemWrite_i;
                    maddr_nxt  = addr_i;
                    mwdata_nxt = wdata_i;
                    cnt_nxt    = '0;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                // Ack takes priority over a timeout falling on the same cycle.
                if (mem.mem_ack_i) begin
                    state_nxt = DONE;
                    req_nxt   = 1'b0;
                    hold_nxt  = mem.mem_we_o ? '0 : mem.mem_rdata_i;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    req_nxt   = 1'b0;
                    hold_nxt  = '0;
                    tmo_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE: begin
                data_o    = hold;
                WB_o      = timeout_o ? 2'b00 : WB_i;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed transactions expanded by a transaction-level model into a queue of
// expected per-cycle outputs; one compare process checks the DUT against the
// queue on every falling edge. A few literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [1:0]  WB_i = 2'b00;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [4:0]  RegDst_i = '0;
    logic        stall_o, misalign_o, timeout_o;
    logic [1:0]  WB_o;
    logic [31:0] data_o, addr_o;
    logic [4:0]  RegDst_o;

    always #5 clk_i = ~clk_i;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .WB_i(WB_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .RegDst_i(RegDst_i),
        .mem(bus),
        .stall_o(stall_o), .WB_o(WB_o), .data_o(data_o), .addr_o(addr_o),
        .RegDst_o(RegDst_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    typedef struct packed {
        logic        rst, valid, rd, wr;
        logic [1:0]  wb;
        logic [31:0] addr, wdata;
        logic [4:0]  rg;
        logic        ack;
        logic [31:0] rdata;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic [1:0]  wb;
        logic        mis;
        logic        pchk;   // check data_o/addr_o/RegDst_o
        logic [31:0] data, addr;
        logic [4:0]  rg;
        logic        tmo, req, we;
        logic [31:0] maddr, mwdata;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_err = 0;
    int   run = 0, last_run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, want, $time);
        end
    endtask

    // Compare process: one expected record per cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("stall_o", 32'(stall_o), 32'(e.stall));
            chk("WB_o", 32'(WB_o), 32'(e.wb));
            chk("misalign_o", 32'(misalign_o), 32'(e.mis));
            chk("timeout_o", 32'(timeout_o), 32'(e.tmo));
            chk("mem_req_o", 32'(bus.mem_req_o), 32'(e.req));
            if (e.pchk) begin
                chk("data_o", data_o, e.data);
                chk("addr_o", addr_o, e.addr);
                chk("RegDst_o", 32'(RegDst_o), 32'(e.rg));
            end
            if (e.req) begin
                chk("mem_we_o", 32'(bus.mem_we_o), 32'(e.we));
                chk("mem_addr_o", bus.mem_addr_o, e.maddr);
                chk("mem_wdata_o", bus.mem_wdata_o, e.mwdata);
            end
        end
        if (stall_o === 1'b1) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    task automatic step(input stim_t s, input exp_t e);
        @(posedge clk_i);
        #1;
        rst_i = s.rst; valid_i = s.valid; MemRead_i = s.rd; MemWrite_i = s.wr;
        WB_i = s.wb; addr_i = s.addr; wdata_i = s.wdata; RegDst_i = s.rg;
        bus.mem_ack_i = s.ack; bus.mem_rdata_i = s.rdata;
        q.push_back(e);
    endtask

    // Non-memory instruction (or empty slot); optional stray ack.
    task automatic alu_op(input logic v, input logic [1:0] wb, input logic [31:0] a,
                          input logic [4:0] rg, input logic ack, input logic rst);
        stim_t s;
        exp_t  e;
        s = '0; e = '0;
        s.rst = rst; s.valid = v; s.wb = wb; s.addr = a; s.rg = rg;
        s.ack = ack; s.rdata = $urandom;
        e.wb = v ? wb : 2'b00; e.pchk = 1'b1; e.addr = a; e.rg = rg;
        step(s, e);
    endtask

    // Memory op; ack arrives on the k-th request cycle (k outside 1..TO: none).
    task automatic mem_op(input logic is_rd, input logic is_wr, input logic [1:0] wb,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rg,
                          input int k, input logic [31:0] rd_data, input logic ack_in_done);
        stim_t s;
        exp_t  e;
        bit    acked;
        int    w;
        acked = (k >= 1 && k <= TO);
        w = acked ? k : TO;
        s = '0;
        s.rst = 1'b1; s.valid = 1'b1; s.rd = is_rd; s.wr = is_wr; s.wb = wb;
        s.addr = a; s.wdata = wd; s.rg = rg; s.rdata = $urandom;
        e = '0;
        if (a[1:0] != 2'b00) begin
            e.mis = 1'b1;
            step(s, e);
            return;
        end
        e.stall = 1'b1;
        step(s, e);
        e.req = 1'b1; e.we = is_wr; e.maddr = a; e.mwdata = wd;
        for (int j = 1; j <= w; j++) begin
            s.ack = acked && (j == w);
            s.rdata = s.ack ? rd_data : $urandom;
            step(s, e);
        end
        s.ack = ack_in_done; s.rdata = $urandom;
        e = '0;
        e.pchk = 1'b1; e.addr = a; e.rg = rg;
        e.data = (acked && !is_wr) ? rd_data : 32'h0;
        e.wb = acked ? wb : 2'b00;
        e.tmo = !acked;
        step(s, e);
    endtask

    task automatic settle();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = '0;

        // Reset, with a stray ack
        alu_op(1'b0, 2'b11, 32'h0, 5'd0, 1'b1, 1'b0);
        alu_op(1'b0, 2'b11, 32'h0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("reset_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("reset_timeout", 32'(timeout_o), 32'h0);

        // ALU pass-through
        alu_op(1'b1, 2'b10, 32'h0000_0040, 5'd5, 1'b0, 1'b1);
        settle();
        chk("alu_WB", 32'(WB_o), 32'h2);
        chk("alu_addr", addr_o, 32'h40);
        chk("alu_RegDst", 32'(RegDst_o), 32'd5);
        alu_op(1'b0, 2'b11, 32'h1234_5678, 5'd31, 1'b0, 1'b1);

        // Load, ack after 3; stray acks in DONE and in following IDLE
        mem_op(1'b1, 1'b0, 2'b11, 32'h100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF, 1'b1);
        settle();
        chk("load_stall_cycles", 32'(last_run), 32'd4);
        chk("load_data", data_o, 32'hDEAD_BEEF);
        chk("load_WB", 32'(WB_o), 32'h3);
        alu_op(1'b1, 2'b10, 32'h44, 5'd3, 1'b1, 1'b1);
        alu_op(1'b1, 2'b10, 32'h48, 5'd4, 1'b0, 1'b1);

        // Store, ack after 1
        mem_op(1'b0, 1'b1, 2'b00, 32'h204, 32'h1234_5678, 5'd0, 1, 32'hFFFF_FFFF, 1'b0);
        settle();
        chk("store_stall_cycles", 32'(last_run), 32'd2);
        chk("store_data", data_o, 32'h0);

        // Read+write together behaves as store
        mem_op(1'b1, 1'b1, 2'b10, 32'h300, 32'hA5A5_0F0F, 5'd9, 2, 32'h5555_AAAA, 1'b0);

        // Misaligned accesses
        mem_op(1'b1, 1'b0, 2'b11, 32'h102, 32'h0, 5'd2, 1, 32'h0, 1'b0);
        settle();
        chk("misalign_flag", 32'(misalign_o), 32'h1);
        chk("misalign_req", 32'(bus.mem_req_o), 32'h0);
        mem_op(1'b0, 1'b1, 2'b00, 32'h201, 32'h1, 5'd0, 1, 32'h0, 1'b0);
        mem_op(1'b1, 1'b0, 2'b11, 32'h3FF, 32'h0, 5'd2, 1, 32'h0, 1'b0);
        alu_op(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 1'b1);

        // Timeout
        mem_op(1'b1, 1'b0, 2'b11, 32'h400, 32'h0, 5'd8, 0, 32'h0, 1'b0);
        settle();
        chk("tmo_pulse", 32'(timeout_o), 32'h1);
        chk("tmo_stall_cycles", 32'(last_run), 32'd5);
        chk("tmo_WB", 32'(WB_o), 32'h0);
        chk("tmo_data", data_o, 32'h0);

        // Ack on the timeout cycle wins; then back-to-back load
        mem_op(1'b1, 1'b0, 2'b11, 32'h500, 32'h0, 5'd10, TO, 32'hCAFE_F00D, 1'b0);
        settle();
        chk("ack_wins_tmo", 32'(timeout_o), 32'h0);
        chk("ack_wins_data", data_o, 32'hCAFE_F00D);
        mem_op(1'b1, 1'b0, 2'b10, 32'h504, 32'h0, 5'd11, 2, 32'h0BAD_F00D, 1'b0);

        // Reset on the second WAIT cycle, late ack afterwards
        s = '0; e = '0;
        s.rst = 1'b1; s.valid = 1'b1; s.rd = 1'b1; s.wb = 2'b11;
        s.addr = 32'h600; s.wdata = 32'h77; s.rg = 5'd12;
        e.stall = 1'b1;
        step(s, e);
        e.req = 1'b1; e.maddr = 32'h600; e.mwdata = 32'h77;
        step(s, e);
        s.rst = 1'b0;
        step(s, e);
        alu_op(1'b0, 2'b11, 32'h600, 5'd12, 1'b1, 1'b1);
        settle();
        chk("rst_wait_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_wait_tmo", 32'(timeout_o), 32'h0);
        alu_op(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 1'b1);
        alu_op(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 1'b1);
        settle();
        chk("rst_wait_stall", 32'(stall_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
